// File: rtl/tile_write_arbiter.sv
// Shares exmem port 2 between the pixel generator (reads while bright) and two
// tile-map writers, each behind a small FIFO drained round-robin during blanking.
module tile_write_arbiter #(
    parameter logic [15:0] BASE_ADDR  = 16'd40000,
    parameter logic [15:0] ROW_WORDS  = 16'd160,
    parameter logic [15:0] ROWS       = 16'd120,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bright,
    input  logic [15:0] pix_addr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_din,
    output logic        mem_we,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [15:0] req_x0,
    input  logic [15:0] req_y0,
    input  logic [15:0] req_x1,
    input  logic [15:0] req_y1,
    input  logic [15:0] req_glyph0,
    input  logic [15:0] req_glyph1,
    output logic [1:0]  err,
    output logic [15:0] wr_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    // The tile address is computed once at push time; 16-bit wrap is intended.
    function automatic logic [15:0] tile_addr(input logic [15:0] x, input logic [15:0] y);
        tile_addr = BASE_ADDR + x + (y * ROW_WORDS);
    endfunction

    function automatic logic fifo_full(input logic [PW-1:0] wp, input logic [PW-1:0] rp);
        fifo_full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    endfunction

    logic [15:0]   x_s         [2];
    logic [15:0]   y_s         [2];
    logic [15:0]   glyph_s     [2];
    logic [PW-1:0] wr_ptr_r    [2];
    logic [PW-1:0] rd_ptr_r    [2];
    logic [15:0]   addr_mem_r  [2][FIFO_DEPTH];
    logic [15:0]   glyph_mem_r [2][FIFO_DEPTH];

    logic [1:0]    empty_s;
    logic [1:0]    full_s;
    logic [1:0]    accept_s;
    logic [1:0]    push_s;
    logic [1:0]    bad_s;
    logic [1:0]    pop_s;
    logic          last_grant_r;
    logic          grant_idx_s;
    logic          grant_valid_s;
    logic [AW-1:0] head_slot_s;
    logic [15:0]   head_addr_s;
    logic [15:0]   head_glyph_s;
    logic [1:0]    err_r;
    logic [15:0]   wr_count_r;

    // Fan the per-requester ports into indexable arrays
    always_comb begin
        x_s[0]     = req_x0;
        x_s[1]     = req_x1;
        y_s[0]     = req_y0;
        y_s[1]     = req_y1;
        glyph_s[0] = req_glyph0;
        glyph_s[1] = req_glyph1;
    end

    // FIFO status and classification of incoming requests
    always_comb begin
        empty_s  = 2'b00;
        full_s   = 2'b00;
        accept_s = 2'b00;
        push_s   = 2'b00;
        bad_s    = 2'b00;
        for (int i = 0; i < 2; i++) begin
            empty_s[i]  = (wr_ptr_r[i] == rd_ptr_r[i]);
            full_s[i]   = fifo_full(wr_ptr_r[i], rd_ptr_r[i]);
            accept_s[i] = req_valid[i] && !full_s[i];
            push_s[i]   = accept_s[i] && (x_s[i] < ROW_WORDS) && (y_s[i] < ROWS);
            bad_s[i]    = accept_s[i] && !push_s[i];
        end
    end

    // Ready ignores a same-cycle pop so the handshake never depends on bright
    assign req_ready = ~full_s;

    // Round-robin grant, only while the beam is blanked
    always_comb begin
        grant_valid_s = 1'b0;
        grant_idx_s   = 1'b0;
        if (bright) begin
            grant_valid_s = 1'b0;
        end else if (!empty_s[0] && !empty_s[1]) begin
            grant_valid_s = 1'b1;
            grant_idx_s   = ~last_grant_r;
        end else if (!empty_s[0]) begin
            grant_valid_s = 1'b1;
            grant_idx_s   = 1'b0;
        end else if (!empty_s[1]) begin
            grant_valid_s = 1'b1;
            grant_idx_s   = 1'b1;
        end else begin
            grant_valid_s = 1'b0;
        end
    end

    // Port mux: combinational so a rising bright stops writes with no lag
    always_comb begin
        head_slot_s  = rd_ptr_r[grant_idx_s][AW-1:0];
        head_addr_s  = addr_mem_r[grant_idx_s][head_slot_s];
        head_glyph_s = glyph_mem_r[grant_idx_s][head_slot_s];
        pop_s        = 2'b00;
        mem_we       = 1'b0;
        mem_addr     = pix_addr;
        mem_din      = 16'd0;
        if (grant_valid_s) begin
            mem_we             = 1'b1;
            mem_addr           = head_addr_s;
            mem_din            = head_glyph_s;
            pop_s[grant_idx_s] = 1'b1;
        end else begin
            mem_we   = 1'b0;
            mem_addr = pix_addr;
            mem_din  = 16'd0;
        end
    end

    // FIFO storage and pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                wr_ptr_r[i] <= {PW{1'b0}};
                rd_ptr_r[i] <= {PW{1'b0}};
                for (int j = 0; j < FIFO_DEPTH; j++) begin
                    addr_mem_r[i][j]  <= 16'd0;
                    glyph_mem_r[i][j] <= 16'd0;
                end
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (push_s[i]) begin
                    addr_mem_r[i][wr_ptr_r[i][AW-1:0]]  <= tile_addr(x_s[i], y_s[i]);
                    glyph_mem_r[i][wr_ptr_r[i][AW-1:0]] <= glyph_s[i];
                    wr_ptr_r[i]                          <= wr_ptr_r[i] + PTR_ONE;
                end
                if (pop_s[i]) begin
                    rd_ptr_r[i] <= rd_ptr_r[i] + PTR_ONE;
                end
            end
        end
    end

    // Arbitration history, error pulses and committed-write counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_r <= 1'b1;
            err_r        <= 2'b00;
            wr_count_r   <= 16'd0;
        end else begin
            err_r <= bad_s;
            if (grant_valid_s) begin
                last_grant_r <= grant_idx_s;
                wr_count_r   <= wr_count_r + 16'd1;
            end
        end
    end

    assign err      = err_r;
    assign wr_count = wr_count_r;

endmodule

// File: tb/tb_tile_write_arbiter.sv
// Bench for tile_write_arbiter: directed scenarios plus random traffic, checked
// against a queue-based model of the two write FIFOs and the shared port.
module tb_tile_write_arbiter;

    logic        clk;
    logic        rst_n;
    logic        bright;
    logic [15:0] pix_addr;
    logic [15:0] mem_addr;
    logic [15:0] mem_din;
    logic        mem_we;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [15:0] req_x0, req_y0, req_x1, req_y1, req_glyph0, req_glyph1;
    logic [1:0]  err;
    logic [15:0] wr_count;

    int n_chk  = 0;
    int n_fail = 0;

    tile_write_arbiter dut (
        .clk(clk), .rst_n(rst_n), .bright(bright), .pix_addr(pix_addr),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x0(req_x0), .req_y0(req_y0), .req_x1(req_x1), .req_y1(req_y1),
        .req_glyph0(req_glyph0), .req_glyph1(req_glyph1),
        .err(err), .wr_count(wr_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] glyph;
    } ent_t;

    ent_t       mq0[$];
    ent_t       mq1[$];
    int         m_last;
    int         m_count;
    logic [1:0] m_err;

    function automatic ent_t mk(input int x, input int y, input int g);
        ent_t e;
        e.addr  = 16'((40000 + x + y * 160) % 65536);
        e.glyph = 16'(g);
        return e;
    endfunction

    function automatic int m_grant();
        if (bright) return -1;
        if (mq0.size() > 0 && mq1.size() > 0) return (m_last == 1) ? 0 : 1;
        if (mq0.size() > 0) return 0;
        if (mq1.size() > 0) return 1;
        return -1;
    endfunction

    function automatic void predict(output logic we, output logic [15:0] a,
                                    output logic [15:0] d, output logic [1:0] r);
        int g;
        g  = m_grant();
        we = (g >= 0);
        if (g == 0) begin
            a = mq0[0].addr; d = mq0[0].glyph;
        end else if (g == 1) begin
            a = mq1[0].addr; d = mq1[0].glyph;
        end else begin
            a = pix_addr; d = 16'd0;
        end
        r = {mq1.size() < 4, mq0.size() < 4};
    endfunction

    task automatic m_reset();
        mq0.delete();
        mq1.delete();
        m_last  = 1;
        m_count = 0;
        m_err   = 2'b00;
    endtask

    // Advance the model across one rising edge using the inputs held at that edge
    task automatic model_commit();
        int g, s0, s1;
        logic [1:0] ne;
        g  = m_grant();
        s0 = mq0.size();
        s1 = mq1.size();
        ne = 2'b00;
        if (g == 0) begin
            void'(mq0.pop_front()); m_last = 0; m_count = (m_count + 1) % 65536;
        end else if (g == 1) begin
            void'(mq1.pop_front()); m_last = 1; m_count = (m_count + 1) % 65536;
        end
        if (req_valid[0] && s0 < 4) begin
            if (req_x0 < 160 && req_y0 < 120) mq0.push_back(mk(req_x0, req_y0, req_glyph0));
            else ne[0] = 1'b1;
        end
        if (req_valid[1] && s1 < 4) begin
            if (req_x1 < 160 && req_y1 < 120) mq1.push_back(mk(req_x1, req_y1, req_glyph1));
            else ne[1] = 1'b1;
        end
        m_err = ne;
    endtask

    task automatic tick();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic set_in(input logic b, input logic [1:0] v, input int x0, input int y0,
                          input int g0, input int x1, input int y1, input int g1);
        bright     = b;
        req_valid  = v;
        req_x0     = 16'(x0); req_y0 = 16'(y0); req_glyph0 = 16'(g0);
        req_x1     = 16'(x1); req_y1 = 16'(y1); req_glyph1 = 16'(g1);
        pix_addr   = 16'($urandom);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic e_we; logic [15:0] e_a, e_d; logic [1:0] e_r;
        rst_n = 1'b0;
        set_in(1'b0, 2'b11, 5, 2, 3, 7, 7, 9);
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_chk++;
        if (req_ready !== 2'b11) begin
            n_fail++; $display("FAIL reset_ready: got %b exp 11", req_ready);
        end
        n_chk++;
        if (mem_we !== 1'b0 || mem_addr !== pix_addr || mem_din !== 16'd0) begin
            n_fail++; $display("FAIL reset_port: got we=%b addr=%0d din=%0d exp we=0 addr=%0d din=0",
                               mem_we, mem_addr, mem_din, pix_addr);
        end
        n_chk++;
        if (err !== 2'b00 || wr_count !== 16'd0) begin
            n_fail++; $display("FAIL reset_regs: got err=%b cnt=%0d exp 00/0", err, wr_count);
        end
        set_in(1'b0, 2'b00, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        m_reset();
        tick();
        @(negedge clk);
        predict(e_we, e_a, e_d, e_r);
        n_chk++;
        if ({mem_we, mem_addr, mem_din, req_ready} !== {e_we, e_a, e_d, e_r}) begin
            n_fail++; $display("FAIL post_reset_port: got we=%b addr=%0d rdy=%b exp we=%b addr=%0d rdy=%b",
                               mem_we, mem_addr, req_ready, e_we, e_a, e_r);
        end
        tick();
    endtask

    task automatic test_round_robin();
        logic e_we; logic [15:0] e_a, e_d; logic [1:0] e_r;
        logic [15:0] seq [4];
        seq[0] = 16'h0B00; seq[1] = 16'h0C00; seq[2] = 16'h0B01; seq[3] = 16'h0C01;
        for (int k = 0; k < 2; k++) begin
            set_in(1'b1, 2'b11, 10 + k, 20, 16'h0B00 + k, 30 + k, 40, 16'h0C00 + k);
            tick();
        end
        for (int k = 0; k < 5; k++) begin
            set_in(1'b0, 2'b00, 0, 0, 0, 0, 0, 0);
            @(negedge clk);
            predict(e_we, e_a, e_d, e_r);
            n_chk++;
            if ({mem_we, mem_addr, mem_din} !== {e_we, e_a, e_d}) begin
                n_fail++; $display("FAIL rr_port[%0d]: got we=%b addr=%0d din=%h exp we=%b addr=%0d din=%h",
                                   k, mem_we, mem_addr, mem_din, e_we, e_a, e_d);
            end
            if (k < 4) begin
                n_chk++;
                if (mem_we !== 1'b1 || mem_din !== seq[k]) begin
                    n_fail++; $display("FAIL rr_order[%0d]: got we=%b din=%h exp we=1 din=%h",
                                       k, mem_we, mem_din, seq[k]);
                end
            end else begin
                n_chk++;
                if (wr_count !== 16'd4) begin
                    n_fail++; $display("FAIL rr_count: got %0d exp 4", wr_count);
                end
            end
            tick();
        end
    endtask

    task automatic test_single_write();
        logic e_we; logic [15:0] e_a, e_d; logic [1:0] e_r;
        set_in(1'b0, 2'b01, 5, 2, 3, 0, 0, 0);
        @(negedge clk);
        predict(e_we, e_a, e_d, e_r);
        n_chk++;
        if ({mem_we, mem_addr} !== {e_we, e_a}) begin
            n_fail++; $display("FAIL single_push_cycle: got we=%b addr=%0d exp we=%b addr=%0d",
                               mem_we, mem_addr, e_we, e_a);
        end
        tick();
        set_in(1'b0, 2'b00, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        n_chk++;
        if ({mem_we, mem_addr, mem_din} !== {1'b1, 16'd40325, 16'd3}) begin
            n_fail++; $display("FAIL single_write: got we=%b addr=%0d din=%0d exp we=1 addr=40325 din=3",
                               mem_we, mem_addr, mem_din);
        end
        tick();
        @(negedge clk);
        n_chk++;
        if (wr_count !== 16'(m_count) || req_ready[0] !== 1'b1) begin
            n_fail++; $display("FAIL single_count: got cnt=%0d rdy0=%b exp cnt=%0d rdy0=1",
                               wr_count, req_ready[0], m_count);
        end
        tick();
    endtask

    task automatic test_bright_blocking();
        logic e_we; logic [15:0] e_a, e_d; logic [1:0] e_r;
        for (int k = 0; k < 5; k++) begin
            set_in(1'b1, 2'b01, $urandom_range(0, 159), $urandom_range(0, 119), 100 + k, 0, 0, 0);
            @(negedge clk);
            predict(e_we, e_a, e_d, e_r);
            n_chk++;
            if ({mem_we, mem_addr, req_ready} !== {1'b0, pix_addr, e_r}) begin
                n_fail++; $display("FAIL bb_fill[%0d]: got we=%b addr=%0d rdy=%b exp we=0 addr=%0d rdy=%b",
                                   k, mem_we, mem_addr, req_ready, pix_addr, e_r);
            end
            if (k == 4) begin
                n_chk++;
                if (req_ready[0] !== 1'b0) begin
                    n_fail++; $display("FAIL bb_full: got rdy0=%b exp 0", req_ready[0]);
                end
            end
            tick();
        end
        for (int k = 0; k < 5; k++) begin
            set_in(1'b0, 2'b00, 0, 0, 0, 0, 0, 0);
            @(negedge clk);
            predict(e_we, e_a, e_d, e_r);
            n_chk++;
            if ({mem_we, mem_addr, mem_din} !== {e_we, e_a, e_d} || (k < 4 && mem_din !== 16'(100 + k))) begin
                n_fail++; $display("FAIL bb_drain[%0d]: got we=%b addr=%0d din=%0d exp we=%b addr=%0d din=%0d",
                                   k, mem_we, mem_addr, mem_din, e_we, e_a, e_d);
            end
            tick();
        end
    endtask

    task automatic test_range_err();
        set_in(1'b0, 2'b11, 0, 120, 11, 160, 0, 12);
        tick();
        set_in(1'b0, 2'b00, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        n_chk++;
        if (err !== 2'b11 || mem_we !== 1'b0 || req_ready !== 2'b11) begin
            n_fail++; $display("FAIL range_err: got err=%b we=%b rdy=%b exp err=11 we=0 rdy=11",
                               err, mem_we, req_ready);
        end
        tick();
        @(negedge clk);
        n_chk++;
        if (err !== 2'b00 || mem_we !== 1'b0) begin
            n_fail++; $display("FAIL range_err_len: got err=%b we=%b exp err=00 we=0", err, mem_we);
        end
        tick();
        set_in(1'b0, 2'b01, 159, 119, 13, 0, 0, 0);
        tick();
        set_in(1'b0, 2'b00, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        n_chk++;
        if ({mem_we, mem_addr, mem_din, err} !== {1'b1, 16'd59199, 16'd13, 2'b00}) begin
            n_fail++; $display("FAIL range_max: got we=%b addr=%0d din=%0d err=%b exp we=1 addr=59199 din=13 err=00",
                               mem_we, mem_addr, mem_din, err);
        end
        tick();
    endtask

    task automatic test_blanking_boundary();
        logic e_we; logic [15:0] e_a, e_d; logic [1:0] e_r;
        int nw;
        nw = 0;
        for (int k = 0; k < 3; k++) begin
            set_in(1'b1, 2'b01, 7 * k, 3 * k, 200 + k, 0, 0, 0);
            tick();
        end
        for (int k = 0; k < 8; k++) begin
            set_in((k >= 2) ? 1'b1 : 1'b0, 2'b00, 0, 0, 0, 0, 0, 0);
            @(negedge clk);
            predict(e_we, e_a, e_d, e_r);
            nw += int'(mem_we);
            n_chk++;
            if ({mem_we, mem_addr, mem_din} !== {e_we, e_a, e_d}) begin
                n_fail++; $display("FAIL blank_port[%0d]: got we=%b addr=%0d din=%0d exp we=%b addr=%0d din=%0d",
                                   k, mem_we, mem_addr, mem_din, e_we, e_a, e_d);
            end
            tick();
        end
        n_chk++;
        if (nw !== 2) begin
            n_fail++; $display("FAIL blank_writes: got %0d exp 2", nw);
        end
        set_in(1'b0, 2'b00, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        n_chk++;
        if ({mem_we, mem_din} !== {1'b1, 16'd202}) begin
            n_fail++; $display("FAIL blank_third: got we=%b din=%0d exp we=1 din=202", mem_we, mem_din);
        end
        tick();
    endtask

    task automatic test_random();
        logic e_we; logic [15:0] e_a, e_d; logic [1:0] e_r;
        for (int k = 0; k < 420; k++) begin
            if (k < 400)
                set_in($urandom_range(0, 2) == 0, 2'($urandom),
                       $urandom_range(0, 170), $urandom_range(0, 125), $urandom,
                       $urandom_range(0, 170), $urandom_range(0, 125), $urandom);
            else
                set_in(1'b0, 2'b00, 0, 0, 0, 0, 0, 0);
            @(negedge clk);
            predict(e_we, e_a, e_d, e_r);
            n_chk++;
            if ({mem_we, mem_addr, mem_din} !== {e_we, e_a, e_d}) begin
                n_fail++; $display("FAIL rnd_port[%0d]: got we=%b addr=%0d din=%0d exp we=%b addr=%0d din=%0d",
                                   k, mem_we, mem_addr, mem_din, e_we, e_a, e_d);
            end
            n_chk++;
            if (req_ready !== e_r) begin
                n_fail++; $display("FAIL rnd_ready[%0d]: got %b exp %b", k, req_ready, e_r);
            end
            n_chk++;
            if (err !== m_err || wr_count !== 16'(m_count)) begin
                n_fail++; $display("FAIL rnd_regs[%0d]: got err=%b cnt=%0d exp err=%b cnt=%0d",
                                   k, err, wr_count, m_err, m_count);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        set_in(1'b1, 2'b11, 1, 1, 31, 2, 2, 32);
        tick();
        set_in(1'b1, 2'b01, 3, 3, 33, 0, 0, 0);
        tick();
        set_in(1'b0, 2'b00, 0, 0, 0, 0, 0, 0);
        #2;
        n_chk++;
        if (mem_we !== 1'b1) begin
            n_fail++; $display("FAIL mid_pre_we: got %b exp 1", mem_we);
        end
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (mem_we !== 1'b0 || mem_addr !== pix_addr) begin
            n_fail++; $display("FAIL mid_async_we: got we=%b addr=%0d exp we=0 addr=%0d", mem_we, mem_addr, pix_addr);
        end
        m_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        n_chk++;
        if (req_ready !== 2'b11 || wr_count !== 16'd0 || mem_we !== 1'b0) begin
            n_fail++; $display("FAIL mid_after: got rdy=%b cnt=%0d we=%b exp rdy=11 cnt=0 we=0",
                               req_ready, wr_count, mem_we);
        end
        tick();
        set_in(1'b1, 2'b11, 4, 4, 21, 5, 5, 22);
        tick();
        set_in(1'b0, 2'b00, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        n_chk++;
        if ({mem_we, mem_din} !== {1'b1, 16'd21}) begin
            n_fail++; $display("FAIL mid_tie_blue: got we=%b din=%0d exp we=1 din=21", mem_we, mem_din);
        end
        tick();
        @(negedge clk);
        n_chk++;
        if ({mem_we, mem_din, wr_count} !== {1'b1, 16'd22, 16'd1}) begin
            n_fail++; $display("FAIL mid_tie_yellow: got we=%b din=%0d cnt=%0d exp we=1 din=22 cnt=1",
                               mem_we, mem_din, wr_count);
        end
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(1'b1, 2'b00, 0, 0, 0, 0, 0, 0);
        m_reset();
        test_reset();
        test_round_robin();
        test_single_write();
        test_bright_blocking();
        test_range_err();
        test_blanking_boundary();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
